// File: rtl/hilo_mdu_pkg.sv
// Shared op codes and helpers for the HI/LO multiply/divide unit.
package hilo_mdu_pkg;

   localparam logic [4:0] SIG_MDU_MULT  = 5'd0;
   localparam logic [4:0] SIG_MDU_MULTU = 5'd1;
   localparam logic [4:0] SIG_MDU_DIV   = 5'd2;
   localparam logic [4:0] SIG_MDU_DIVU  = 5'd3;
   localparam logic [4:0] SIG_MDU_MTHI  = 5'd4;
   localparam logic [4:0] SIG_MDU_MTLO  = 5'd5;

   // Magnitude of a 32-bit operand; only negative values of a signed op are flipped.
   function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
      mag32 = (sgn && v[31]) ? (32'd0 - v) : v;
   endfunction

endpackage

// File: rtl/div_core_radix2.sv
// Unsigned restoring radix-2 divider datapath: 64-bit remainder:quotient
// shift register, step counter and one subtract-and-restore step per step pulse.
module div_core_radix2
   import hilo_mdu_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic        step,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   output logic [31:0] quotient,
   output logic [31:0] remainder,
   output logic        last
);

   logic [63:0] rq_r;
   logic [31:0] dvs_r;
   logic [4:0]  cnt_r;
   logic [32:0] prem_s;
   logic [33:0] trial_s;
   logic [63:0] rq_next_s;

   // Partial remainder is 33 bits wide once shifted, so the trial subtract keeps a borrow bit.
   always_comb begin
      prem_s  = rq_r[63:31];
      trial_s = {1'b0, prem_s} - {2'b00, dvs_r};
      if (!trial_s[33]) begin
         rq_next_s = {trial_s[31:0], rq_r[30:0], 1'b1};
      end else begin
         rq_next_s = {prem_s[31:0], rq_r[30:0], 1'b0};
      end
   end

   // Shift register, divisor and step counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rq_r  <= 64'd0;
         dvs_r <= 32'd0;
         cnt_r <= 5'd0;
      end else if (load) begin
         rq_r  <= {32'd0, dividend};
         dvs_r <= divisor;
         cnt_r <= 5'd0;
      end else if (step) begin
         rq_r  <= rq_next_s;
         cnt_r <= cnt_r + 5'd1;
      end
   end

   assign quotient  = rq_r[31:0];
   assign remainder = rq_r[63:32];
   assign last      = (cnt_r == 5'd31);

endmodule

// File: rtl/hilo_mdu.sv
// HI/LO multiply/divide unit: MULT/MULTU/DIV/DIVU/MTHI/MTLO with busy, done and cancel.
// Optional macro MDU_DIV_ZERO_FAST_EN: divide by zero finishes after one edge and pulses div_zero.
module hilo_mdu
   import hilo_mdu_pkg::*;
#(
   parameter int MUL_LAT = 2
)
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [4:0]  op,
   input  logic        start,
   input  logic        cancel,
   output logic [63:0] hilo,
   output logic        busy,
   output logic        done,
   output logic        div_zero
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_FIX  = 2'd3
   } state_e;

   localparam logic [2:0] MUL_LAST = 3'(MUL_LAT - 1);

   state_e      state_r, state_s;
   logic [63:0] hilo_r;
   logic        done_r, done_s;
   logic        hi_we_s, lo_we_s;
   logic [31:0] hi_wd_s, lo_wd_s;
   logic        mul_load_s, div_load_s, div_step_s, div_last_s, div_sgn_s;
   logic [31:0] op_a_r, op_b_r;
   logic        mul_sgn_r;
   logic [2:0]  mul_cnt_r;
   logic [63:0] prod_s, prod_r, mul_res_s;
   logic        a_neg_r, q_neg_r, b_zero_r;
   logic [31:0] quo_s, rem_s;
`ifdef MDU_DIV_ZERO_FAST_EN
   logic        dz_s, div_zero_r;
`endif

   assign div_sgn_s = (op == SIG_MDU_DIV);
   assign prod_s    = {{32{mul_sgn_r & op_a_r[31]}}, op_a_r} * {{32{mul_sgn_r & op_b_r[31]}}, op_b_r};
   assign mul_res_s = (MUL_LAT == 1) ? prod_s : prod_r;

   div_core_radix2 u_div (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (div_load_s),
      .step      (div_step_s),
      .dividend  (mag32(a, div_sgn_s)),
      .divisor   (mag32(b, div_sgn_s)),
      .quotient  (quo_s),
      .remainder (rem_s),
      .last      (div_last_s)
   );

   // Next state, HI/LO write strobes and completion pulses.
   always_comb begin
      state_s    = state_r;
      hi_we_s    = 1'b0;
      lo_we_s    = 1'b0;
      hi_wd_s    = hilo_r[63:32];
      lo_wd_s    = hilo_r[31:0];
      done_s     = 1'b0;
      mul_load_s = 1'b0;
      div_load_s = 1'b0;
      div_step_s = 1'b0;
`ifdef MDU_DIV_ZERO_FAST_EN
      dz_s       = 1'b0;
`endif
      case (state_r)
         ST_IDLE: begin
            if (start && !cancel) begin
               case (op)
                  SIG_MDU_MULT, SIG_MDU_MULTU: begin
                     mul_load_s = 1'b1;
                     state_s    = ST_MUL;
                  end
                  SIG_MDU_DIV, SIG_MDU_DIVU: begin
                     div_load_s = 1'b1;
                     state_s    = ST_DIV;
                  end
                  SIG_MDU_MTHI: begin
                     hi_we_s = 1'b1;
                     hi_wd_s = a;
                     done_s  = 1'b1;
                  end
                  SIG_MDU_MTLO: begin
                     lo_we_s = 1'b1;
                     lo_wd_s = a;
                     done_s  = 1'b1;
                  end
                  default: state_s = ST_IDLE;
               endcase
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_MUL: begin
            if (cancel) begin
               state_s = ST_IDLE;
            end else if (mul_cnt_r == MUL_LAST) begin
               hi_we_s = 1'b1;
               lo_we_s = 1'b1;
               hi_wd_s = mul_res_s[63:32];
               lo_wd_s = mul_res_s[31:0];
               done_s  = 1'b1;
               state_s = ST_IDLE;
            end else begin
               state_s = ST_MUL;
            end
         end
         ST_DIV: begin
            if (cancel) begin
               state_s = ST_IDLE;
`ifdef MDU_DIV_ZERO_FAST_EN
            end else if (b_zero_r) begin
               done_s  = 1'b1;
               dz_s    = 1'b1;
               state_s = ST_IDLE;
`endif
            end else begin
               div_step_s = 1'b1;
               state_s    = div_last_s ? ST_FIX : ST_DIV;
            end
         end
         ST_FIX: begin
            if (cancel) begin
               state_s = ST_IDLE;
            end else begin
               // A zero divisor keeps the all-ones quotient; the remainder fix-up then reproduces a.
               hi_we_s = 1'b1;
               lo_we_s = 1'b1;
               hi_wd_s = a_neg_r ? (32'd0 - rem_s) : rem_s;
               lo_wd_s = (q_neg_r && !b_zero_r) ? (32'd0 - quo_s) : quo_s;
               done_s  = 1'b1;
               state_s = ST_IDLE;
            end
         end
         default: state_s = ST_IDLE;
      endcase
   end

   // State register and HI/LO result register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         hilo_r  <= 64'd0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         done_r  <= done_s;
         if (hi_we_s) hilo_r[63:32] <= hi_wd_s;
         if (lo_we_s) hilo_r[31:0]  <= lo_wd_s;
      end
   end

   // Multiplier operand latch, product pipeline and latency counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_a_r    <= 32'd0;
         op_b_r    <= 32'd0;
         mul_sgn_r <= 1'b0;
         mul_cnt_r <= 3'd0;
         prod_r    <= 64'd0;
      end else if (mul_load_s) begin
         op_a_r    <= a;
         op_b_r    <= b;
         mul_sgn_r <= (op == SIG_MDU_MULT);
         mul_cnt_r <= 3'd0;
      end else if (state_r == ST_MUL) begin
         prod_r    <= prod_s;
         mul_cnt_r <= mul_cnt_r + 3'd1;
      end
   end

   // Sign bookkeeping for the divide fix-up.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_neg_r  <= 1'b0;
         q_neg_r  <= 1'b0;
         b_zero_r <= 1'b0;
      end else if (div_load_s) begin
         a_neg_r  <= div_sgn_s & a[31];
         q_neg_r  <= div_sgn_s & (a[31] ^ b[31]);
         b_zero_r <= (b == 32'd0);
      end
   end

`ifdef MDU_DIV_ZERO_FAST_EN
   // Divide-by-zero flag pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_zero_r <= 1'b0;
      end else begin
         div_zero_r <= dz_s;
      end
   end
   assign div_zero = div_zero_r;
`else
   assign div_zero = 1'b0;
`endif

   assign hilo = hilo_r;
   assign busy = (state_r != ST_IDLE);
   assign done = done_r;

endmodule
